// File: rtl/tug_field.sv
// Tug-of-war playfield: a human key and a computer player pull a single light
// toward their own end; reaching the end wins a round, WIN_SCORE rounds win the match.
module tug_field #(
  parameter int ROUND_GAP = 8,
  parameter int WIN_SCORE = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       human_in,
  input  logic       cyber_in,
  output logic [8:0] led,
  output logic [2:0] score_human,
  output logic [2:0] score_cyber,
  output logic       round_win_human,
  output logic       round_win_cyber,
  output logic       match_over
);

  typedef enum logic [1:0] {PLAY, GAP, OVER} state_t;

  localparam logic [2:0] WIN_LAST = 3'(WIN_SCORE - 1);
  localparam logic [7:0] GAP_LAST = 8'(ROUND_GAP - 1);
  localparam logic [3:0] POS_CTR  = 4'd4;
  localparam logic [3:0] POS_HUM  = 4'd8;
  localparam logic [3:0] POS_CYB  = 4'd0;

  state_t     state;
  logic [3:0] pos;
  logic [7:0] gap_cnt;

  logic h_sync_p0;
  logic h_sync_p1;
  logic h_prev;
  logic c_prev;
  logic press_h;
  logic press_c;

  function automatic logic [8:0] onehot(input logic [3:0] p);
    onehot = 9'(1) << p;
  endfunction

  // Edge detectors stay live in every state so a level held across GAP exit never counts.
  assign press_h = h_sync_p1 & ~h_prev;
  assign press_c = cyber_in & ~c_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= PLAY;
      pos             <= POS_CTR;
      led             <= onehot(POS_CTR);
      gap_cnt         <= '0;
      score_human     <= '0;
      score_cyber     <= '0;
      round_win_human <= 1'b0;
      round_win_cyber <= 1'b0;
      match_over      <= 1'b0;
      h_sync_p0       <= 1'b0;
      h_sync_p1       <= 1'b0;
      h_prev          <= 1'b0;
      c_prev          <= 1'b0;
    end else begin
      h_sync_p0       <= human_in;
      h_sync_p1       <= h_sync_p0;
      h_prev          <= h_sync_p1;
      c_prev          <= cyber_in;
      round_win_human <= 1'b0;
      round_win_cyber <= 1'b0;

      case (state)
        PLAY: begin
          if (press_h && !press_c) begin
            if (pos != POS_HUM) begin
              pos <= pos + 4'd1;
              led <= onehot(pos + 4'd1);
            end else begin
              score_human     <= score_human + 3'd1;
              round_win_human <= 1'b1;
              gap_cnt         <= '0;
              if (score_human == WIN_LAST) begin
                state      <= OVER;
                match_over <= 1'b1;
              end else begin
                state <= GAP;
              end
            end
          end else if (press_c && !press_h) begin
            if (pos != POS_CYB) begin
              pos <= pos - 4'd1;
              led <= onehot(pos - 4'd1);
            end else begin
              score_cyber     <= score_cyber + 3'd1;
              round_win_cyber <= 1'b1;
              gap_cnt         <= '0;
              if (score_cyber == WIN_LAST) begin
                state      <= OVER;
                match_over <= 1'b1;
              end else begin
                state <= GAP;
              end
            end
          end
        end

        // The light rests at the winner's end for ROUND_GAP cycles, then recentres.
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            pos     <= POS_CTR;
            led     <= onehot(POS_CTR);
            state   <= PLAY;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        OVER: begin
          state <= OVER;
        end

        default: begin
          state <= PLAY;
          pos   <= POS_CTR;
          led   <= onehot(POS_CTR);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_field.sv
// Bench for tug_field: a per-edge behavioural model of the game plus directed
// scenarios with literal expectations and a randomized play phase.
module tb_tug_field;

  localparam int RG = 8;
  localparam int WS = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       human_in = 1'b0;
  logic       cyber_in = 1'b0;
  logic [8:0] led;
  logic [2:0] score_human;
  logic [2:0] score_cyber;
  logic       round_win_human;
  logic       round_win_cyber;
  logic       match_over;

  int n_assert = 0;
  int n_fail   = 0;

  tug_field #(.ROUND_GAP(RG), .WIN_SCORE(WS)) dut (
    .clk(clk),
    .reset(reset),
    .human_in(human_in),
    .cyber_in(cyber_in),
    .led(led),
    .score_human(score_human),
    .score_cyber(score_cyber),
    .round_win_human(round_win_human),
    .round_win_cyber(round_win_cyber),
    .match_over(match_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game state plus the recent input history that defines presses.
  int m_pos = 4, m_sh = 0, m_sc = 0, m_gap = 0;
  bit m_over = 0, m_rwh = 0, m_rwc = 0;
  bit h1 = 0, h2 = 0, h3 = 0, cprev = 0;
  bit started = 0;

  always @(posedge clk) begin
    bit r, h, c, ph, pc;
    r = reset; h = human_in; c = cyber_in;
    if (r) begin
      m_pos = 4; m_sh = 0; m_sc = 0; m_gap = 0;
      m_over = 0; m_rwh = 0; m_rwc = 0;
      h1 = 0; h2 = 0; h3 = 0; cprev = 0;
      started = 1;
    end else begin
      ph = h2 && !h3;
      pc = c && !cprev;
      m_rwh = 0; m_rwc = 0;
      if (m_over) begin
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) m_pos = 4;
      end else if (ph && !pc) begin
        if (m_pos < 8) m_pos++;
        else begin
          m_sh++; m_rwh = 1;
          if (m_sh >= WS) m_over = 1; else m_gap = RG;
        end
      end else if (pc && !ph) begin
        if (m_pos > 0) m_pos--;
        else begin
          m_sc++; m_rwc = 1;
          if (m_sc >= WS) m_over = 1; else m_gap = RG;
        end
      end
      h3 = h2; h2 = h1; h1 = h; cprev = c;
    end
    #1;
    if (started) begin
      chk("model_led", int'(led), 1 << m_pos);
      chk("model_score_human", int'(score_human), m_sh);
      chk("model_score_cyber", int'(score_cyber), m_sc);
      chk("model_round_win_human", int'(round_win_human), int'(m_rwh));
      chk("model_round_win_cyber", int'(round_win_cyber), int'(m_rwc));
      chk("model_match_over", int'(match_over), int'(m_over));
    end
  end

  // Drive one cycle: inputs change well after the edge, return just after the next edge's compare.
  task automatic cyc(input bit h, input bit c, input bit r);
    human_in = h; cyber_in = c; reset = r;
    @(posedge clk);
    #2;
  endtask

  task automatic cpress();
    cyc(0, 1, 0);
    cyc(0, 0, 0);
  endtask

  task automatic hpress();
    cyc(1, 0, 0);
    cyc(0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  initial begin
    #2;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("reset_led", int'(led), 'h010);
    chk("reset_scores", int'({score_human, score_cyber}), 0);
    chk("reset_match_over", int'(match_over), 0);
    cyc(0, 0, 0);

    // Cyber walk to its end.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0); cyc(0, 1, 0);
      cyc(0, 0, 0); cyc(0, 0, 0);
    end
    chk("walk_led", int'(led), 'h001);
    chk("walk_scores", int'({score_human, score_cyber}), 0);

    // Cyber round win and the hold at its end.
    cyc(0, 1, 0);
    chk("win_pulse", int'(round_win_cyber), 1);
    chk("win_score", int'(score_cyber), 1);
    chk("win_led", int'(led), 'h001);
    cyc(0, 0, 0);
    chk("win_pulse_drop", int'(round_win_cyber), 0);
    idle(RG - 2);
    chk("gap_hold_led", int'(led), 'h001);
    idle(1);
    chk("gap_exit_led", int'(led), 'h010);

    // Held human key: one step, two edges after the first sample.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("human_lat1", int'(led), 'h010);
    cyc(1, 0, 0);
    chk("human_lat2", int'(led), 'h020);
    for (int i = 0; i < 17; i++) cyc(1, 0, 0);
    chk("human_held", int'(led), 'h020);
    idle(3);

    // Simultaneous presses at centre, then at the human end.
    cpress();
    chk("back_centre", int'(led), 'h010);
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
    chk("simul_centre", int'(led), 'h010);
    for (int i = 0; i < 4; i++) hpress();
    idle(2);
    chk("human_end", int'(led), 'h100);
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0);
    chk("simul_end_led", int'(led), 'h100);
    chk("simul_end_pulse", int'(round_win_human), 0);
    idle(3);

    // Randomized play with occasional resets.
    begin
      bit h, c, r;
      h = 0; c = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(2) == 0) h = ~h;
        if ($urandom_range(2) == 0) c = ~c;
        r = ($urandom_range(299) == 0);
        cyc(h, c, r);
      end
    end

    // Full cyber match, frozen afterwards, then reset.
    cyc(0, 0, 1);
    idle(1);
    for (int rnd = 0; rnd < WS; rnd++) begin
      for (int i = 0; i < 5; i++) cpress();
      idle(RG + 1);
    end
    chk("match_over", int'(match_over), 1);
    chk("match_score", int'(score_cyber), 7);
    chk("match_led", int'(led), 'h001);
    for (int i = 0; i < 4; i++) begin
      hpress();
      cpress();
    end
    idle(3);
    chk("frozen_led", int'(led), 'h001);
    chk("frozen_scores", int'({score_human, score_cyber}), 7);
    chk("frozen_over", int'(match_over), 1);
    cyc(0, 0, 1);
    chk("post_match_led", int'(led), 'h010);
    chk("post_match_scores", int'({score_human, score_cyber}), 0);
    chk("post_match_over", int'(match_over), 0);
    idle(1);

    // Reset against a winning press, and reset in mid-gap.
    for (int i = 0; i < 4; i++) cpress();
    cyc(0, 1, 1);
    chk("rst_win_score", int'(score_cyber), 0);
    chk("rst_win_pulse", int'(round_win_cyber), 0);
    chk("rst_win_led", int'(led), 'h010);
    idle(1);
    for (int i = 0; i < 5; i++) cpress();
    idle(2);
    cyc(0, 0, 1);
    chk("rst_gap_led", int'(led), 'h010);
    chk("rst_gap_score", int'(score_cyber), 0);
    idle(1);
    cpress();
    chk("rst_gap_play", int'(led), 'h008);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tug_field.md
TUG_FIELD -- requirements
Module: tug_field

Interface
REQ-001 Parameter ROUND_GAP, default 8, number of clk cycles the round-over hold lasts (legal 1..255).
REQ-002 Parameter WIN_SCORE, default 7, round wins needed to end the match (legal 1..7).
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 human_in  input  1  raw key level from the human player, asynchronous, active-high.
REQ-006 cyber_in  input  1  computer-player press level, synchronous to clk, active-high.
REQ-007 led  output  9  playfield lights, exactly one bit set at all times; led[4] is centre, led[8] is the human end and led[0] is the cyber end.
REQ-008 score_human  output  3  human round wins, unsigned.
REQ-009 score_cyber  output  3  cyber round wins, unsigned.
REQ-010 round_win_human  output  1  one-cycle pulse when the human wins a round.
REQ-011 round_win_cyber  output  1  one-cycle pulse when the cyber player wins a round.
REQ-012 match_over  output  1  high once either score reaches WIN_SCORE.

Function
REQ-013 human_in SHALL pass through a 2-flop synchronizer, then a rising-edge detector; press_h is one cycle wide per synchronized 0->1 transition.
REQ-014 cyber_in SHALL feed a rising-edge detector only; press_c = cyber_in AND NOT previous-cycle cyber_in.
REQ-015 Latency: human_in first high at clk edge N SHALL move led at edge N+2; cyber_in first high at edge N SHALL move led at edge N.
REQ-016 A held-high input SHALL produce exactly one press; re-press requires a low of at least one cycle after synchronization.
REQ-017 Position pos is 4-bit, range 0..8; led = one-hot of pos.
REQ-018 FSM states: PLAY, GAP, OVER.
REQ-019 PLAY: press_h alone with pos<8 -> pos+1; press_c alone with pos>0 -> pos-1; both presses in the same cycle -> no change.
REQ-020 PLAY: press_h alone with pos==8 -> human round win; press_c alone with pos==0 -> cyber round win; simultaneous presses at an end -> no change.
REQ-021 On a round win the winner's score SHALL increment by 1 and the matching round_win pulse SHALL assert for the next cycle only.
REQ-022 After a win, if the new score < WIN_SCORE go to GAP, otherwise go to OVER and assert match_over.
REQ-023 GAP: pos holds at the winner's end; presses are ignored; a cycle counter runs ROUND_GAP cycles, then pos = 4 and state = PLAY.
REQ-024 Edge detectors SHALL keep tracking during GAP and OVER, so a level held across GAP exit does not create a press.
REQ-025 OVER: pos, scores and match_over are frozen; all presses are ignored until reset.
REQ-026 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.

Reset
REQ-027 When reset is high at a clk edge: state=PLAY, pos=4 (led=9'b000010000), scores=0, pulses=0, match_over=0, synchronizer and edge registers=0, gap counter=0.
REQ-028 Reset SHALL take priority over every event in the same cycle, including a concurrent winning press; mid-GAP or OVER reset returns directly to PLAY at centre.
REQ-029 Outputs SHALL be fully registered.

Verification
REQ-030 Reset, then cyber_in 0->1->0 four times (2 cycles each) -> led walks 0x010,0x008,0x004,0x002,0x001; scores stay 0.
REQ-031 From led=0x001, one more cyber press -> round_win_cyber high exactly 1 cycle, score_cyber=1, led holds 0x001 for ROUND_GAP cycles, then returns to 0x010.
REQ-032 human_in held high for 20 cycles -> exactly one step (led 0x010->0x020), appearing 2 edges after the first high sample.
REQ-033 Align human and cyber presses to the same cycle at pos=4 and at pos=8 -> led unchanged and no win pulse.
REQ-034 Drive cyber rounds until score_cyber=7 -> match_over=1, state frozen; further human and cyber presses change nothing; reset -> led=0x010, scores 0, match_over 0.
REQ-035 Assert reset in the same cycle as a winning press and during GAP -> no score change and no pulse; PLAY at centre on the next cycle.
